// File: rtl/free_play_fsm_n.sv
// rtl/free_play_fsm_n.sv - parametrised free-play key-to-note FSM with filter, min hold and idle timeout
module free_play_fsm_n #(
    parameter int NUM_NOTES     = 4,
    parameter int KEY_W         = 8,
    parameter int NOTE_W        = 3,
    parameter int BASE_KEY      = 97,
    parameter int IDLE_NOTE     = 7,
    parameter int FILTER_CYCLES = 2,
    parameter int MIN_HOLD      = 4,
    parameter int IDLE_TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic              fin,
    input  logic [KEY_W-1:0]  entrada,
    output logic [NOTE_W-1:0] notaSalida,
    output logic              contar,
    output logic              note_start,
    output logic              activo
);

    localparam int FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam int LEN_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int TMO_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    // Key range bounds one bit wider than the key so BASE_KEY+NUM_NOTES never wraps.
    localparam logic [KEY_W:0]    KEY_LO   = (KEY_W + 1)'(BASE_KEY);
    localparam logic [KEY_W:0]    KEY_HI   = (KEY_W + 1)'(BASE_KEY + NUM_NOTES);
    localparam logic [NOTE_W-1:0] NOTE_OFF = NOTE_W'(IDLE_NOTE);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_CYCLES);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MIN_HOLD);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LISTEN = 3'd1,
        S_ARM    = 3'd2,
        S_PLAY   = 3'd3,
        S_TAIL   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NOTE_W-1:0]   cand_q, cand_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                start_d;
    logic [NOTE_W-1:0]   note_q;
    logic                contar_q, start_q, activo_q;

    logic [KEY_W:0]      key_ext;
    logic                key_valid;
    logic [NOTE_W-1:0]   key_idx;
    logic                key_same;
    logic                playing_d;

    // Combinational key decode against the configured contiguous range.
    always_comb begin
        key_ext   = {1'b0, entrada};
        key_valid = (key_ext >= KEY_LO) && (key_ext < KEY_HI);
        key_idx   = NOTE_W'(key_ext - KEY_LO);
        key_same  = key_valid && (key_idx == cand_q);
    end

    // Next-state logic; fin is applied last so it overrides every other transition.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        filt_d  = filt_q;
        len_d   = len_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inicio) begin
                    state_d = S_LISTEN;
                    tmo_d   = '0;
                end
            end
            S_LISTEN: begin
                if (key_valid) begin
                    cand_d = key_idx;
                    filt_d = FILT_W'(1);
                    if (FILTER_CYCLES == 1) begin
                        state_d = S_PLAY;
                        len_d   = LEN_W'(1);
                        start_d = 1'b1;
                    end else begin
                        state_d = S_ARM;
                    end
                end else if (IDLE_TIMEOUT != 0) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_d == TMO_MAX) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ARM: begin
                if (key_same) begin
                    filt_d = filt_q + FILT_W'(1);
                    if (filt_d == FILT_MAX) begin
                        state_d = S_PLAY;
                        len_d   = LEN_W'(1);
                        start_d = 1'b1;
                    end
                end else if (key_valid) begin
                    cand_d = key_idx;
                    filt_d = FILT_W'(1);
                end else begin
                    state_d = S_LISTEN;
                    tmo_d   = '0;
                end
            end
            S_PLAY, S_TAIL: begin
                len_d = (len_q >= LEN_MAX) ? len_q : len_q + LEN_W'(1);
                if (key_same) begin
                    state_d = S_PLAY;
                end else if (len_q >= LEN_MAX) begin
                    state_d = S_LISTEN;
                    tmo_d   = '0;
                end else begin
                    state_d = S_TAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fin) begin
            state_d = S_IDLE;
            start_d = 1'b0;
        end
    end

    assign playing_d = (state_d == S_PLAY) || (state_d == S_TAIL);

    // State, counters and outputs all registered from the next state on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cand_q   <= '0;
            filt_q   <= '0;
            len_q    <= '0;
            tmo_q    <= '0;
            note_q   <= NOTE_OFF;
            contar_q <= 1'b0;
            start_q  <= 1'b0;
            activo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            filt_q   <= filt_d;
            len_q    <= len_d;
            tmo_q    <= tmo_d;
            note_q   <= playing_d ? (cand_d + NOTE_W'(1)) : NOTE_OFF;
            contar_q <= playing_d;
            start_q  <= start_d;
            activo_q <= (state_d != S_IDLE);
        end
    end

    assign notaSalida = note_q;
    assign contar     = contar_q;
    assign note_start = start_q;
    assign activo     = activo_q;

endmodule

// File: tb/tb_free_play_fsm_n.sv
// tb/tb_free_play_fsm_n.sv - randomized and directed bench for free_play_fsm_n against a behavioural model
module tb_free_play_fsm_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       inicio;
    logic       fin;
    logic [7:0] entrada;

    logic [2:0] nota_a, nota_b;
    logic       contar_a, contar_b, start_a, start_b, activo_a, activo_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: mode 0 = off, 1 = listening/arming, 2 = note sounding.
    int   m_mode [2];
    int   m_cand [2];
    int   m_run  [2];
    int   m_quiet[2];
    int   m_held [2];
    int   m_start[2];
    int   p_num  [2] = '{4, 6};
    int   p_base [2] = '{97, 49};
    int   p_filt [2] = '{2, 1};
    int   p_hold [2] = '{4, 4};
    int   p_tmo  [2] = '{8, 20};

    free_play_fsm_n #(
        .IDLE_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(reset), .inicio(inicio), .fin(fin), .entrada(entrada),
        .notaSalida(nota_a), .contar(contar_a), .note_start(start_a), .activo(activo_a)
    );

    free_play_fsm_n #(
        .NUM_NOTES(6), .BASE_KEY(49), .NOTE_W(3), .FILTER_CYCLES(1), .IDLE_TIMEOUT(20)
    ) dut_b (
        .clk(clk), .reset(reset), .inicio(inicio), .fin(fin), .entrada(entrada),
        .notaSalida(nota_b), .contar(contar_b), .note_start(start_b), .activo(activo_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_cand[d] = 0; m_run[d] = 0;
            m_quiet[d] = 0; m_held[d] = 0; m_start[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        int k;
        int key;
        key = int'(entrada);
        k = (key >= p_base[d] && key < p_base[d] + p_num[d]) ? key - p_base[d] + 1 : 0;
        m_start[d] = 0;
        if (fin) begin
            m_mode[d] = 0;
        end else if (m_mode[d] == 0) begin
            if (inicio) begin
                m_mode[d] = 1; m_run[d] = 0; m_quiet[d] = 0;
            end
        end else if (m_mode[d] == 1) begin
            if (k != 0) begin
                if (m_run[d] > 0 && k == m_cand[d]) m_run[d]++;
                else begin m_cand[d] = k; m_run[d] = 1; end
                if (m_run[d] >= p_filt[d]) begin
                    m_mode[d] = 2; m_held[d] = 1; m_start[d] = 1;
                end
            end else if (m_run[d] > 0) begin
                m_run[d] = 0; m_quiet[d] = 0;
            end else begin
                m_quiet[d]++;
                if (p_tmo[d] != 0 && m_quiet[d] >= p_tmo[d]) m_mode[d] = 0;
            end
        end else begin
            if (k != m_cand[d] && m_held[d] >= p_hold[d]) begin
                m_mode[d] = 1; m_run[d] = 0; m_quiet[d] = 0;
            end else if (m_held[d] < p_hold[d]) begin
                m_held[d]++;
            end
        end
    endtask

    task automatic compare_all();
        check("a.nota",   nota_a,   (m_mode[0] == 2) ? m_cand[0] : 7);
        check("a.contar", contar_a, (m_mode[0] == 2) ? 1 : 0);
        check("a.start",  start_a,  m_start[0]);
        check("a.activo", activo_a, (m_mode[0] != 0) ? 1 : 0);
        check("b.nota",   nota_b,   (m_mode[1] == 2) ? m_cand[1] : 7);
        check("b.contar", contar_b, (m_mode[1] == 2) ? 1 : 0);
        check("b.start",  start_b,  m_start[1]);
        check("b.activo", activo_b, (m_mode[1] != 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic go_listen();
        fin = 1'b1; tick();
        fin = 1'b0; inicio = 1'b1; tick();
        inicio = 1'b0;
    endtask

    function automatic logic [7:0] pick_key();
        int r;
        r = $urandom_range(0, 3);
        case (r)
            0:       return 8'd0;
            1:       return 8'($urandom_range(95, 102));
            2:       return 8'($urandom_range(47, 57));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        reset = 1'b0; inicio = 1'b0; fin = 1'b0; entrada = 8'd0;
        model_reset();
        #1 reset = 1'b1;
        #10;
        compare_all();
        check("rst.nota", nota_a, 7);
        check("rst.activo", activo_a, 0);
        #1 reset = 1'b0;

        // Note 1 with the default two-sample filter.
        inicio = 1'b1; tick();
        check("s1.listen", activo_a, 1);
        inicio = 1'b0; entrada = 8'd97;
        tick();
        check("s1.arm_nota", nota_a, 7);
        tick();
        check("s1.nota1", nota_a, 1);
        check("s1.start", start_a, 1);
        tick();
        check("s1.start_once", start_a, 0);
        check("s1.contar", contar_a, 1);
        for (int i = 0; i < 7; i++) tick();
        entrada = 8'd0; tick();
        check("s1.release", contar_a, 0);

        // One-sample glitch never starts a note.
        entrada = 8'd98; tick();
        entrada = 8'd0; tick();
        check("s2.nota", nota_a, 7);
        check("s2.start", start_a, 0);

        // Short press runs out its minimum hold, then a re-press inside the tail.
        entrada = 8'd100; tick(); tick();
        check("s3.nota4", nota_a, 4);
        entrada = 8'd0;
        tick(); tick(); tick();
        check("s3.tail_held", contar_a, 1);
        tick();
        check("s3.tail_done", contar_a, 0);
        check("s3.tail_nota", nota_a, 7);
        entrada = 8'd100; tick(); tick();
        entrada = 8'd0; tick(); tick();
        entrada = 8'd100; tick();
        check("s3.repress_nostart", start_a, 0);
        check("s3.repress_contar", contar_a, 1);
        entrada = 8'd0; tick();
        check("s3.repress_end", contar_a, 0);

        // Out-of-range key in LISTEN, then idle timeout.
        entrada = 8'd101;
        go_listen();
        for (int i = 0; i < 7; i++) tick();
        check("s4.before_tmo", activo_a, 1);
        tick();
        check("s4.timeout", activo_a, 0);

        // fin cuts a sounding note.
        go_listen();
        entrada = 8'd99; tick(); tick();
        check("s5.nota3", nota_a, 3);
        fin = 1'b1; tick();
        fin = 1'b0;
        check("s5.fin_nota", nota_a, 7);
        check("s5.fin_contar", contar_a, 0);

        // Asynchronous reset mid-note.
        go_listen();
        entrada = 8'd99; tick(); tick();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("s6.rst_nota", nota_a, 7);
        check("s6.rst_contar", contar_a, 0);
        check("s6.rst_activo", activo_a, 0);
        #1 reset = 1'b0;
        tick();
        check("s6.no_start", start_a, 0);

        // Swept instance: single-sample filter over keys 49..54.
        entrada = 8'd0;
        go_listen();
        entrada = 8'd54; tick();
        check("s7.nota6", nota_b, 6);
        check("s7.start", start_b, 1);
        entrada = 8'd0;
        go_listen();
        entrada = 8'd55; tick();
        check("s7.reject55", nota_b, 7);
        check("s7.reject_act", activo_b, 1);

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            inicio = ($urandom_range(0, 99) < 15);
            fin    = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) entrada = pick_key();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/free_play_fsm_n.md
Name: free_play_fsm_n

Overview:
- Parametrised successor of the free-play note FSM.
- Maps a configurable contiguous range of ASCII key codes to note codes 1..NUM_NOTES.
- Adds a glitch filter on key press, a minimum note duration, an idle timeout and a one-cycle note-start strobe.
- Sits between the keyboard/UART key decoder and the tone generator / duration counter; `contar` gates the note-duration counter as before.

Parameters:
- NUM_NOTES, 4: number of playable notes, 1..(2^NOTE_W)-2.
- KEY_W, 8: width of the key code input.
- NOTE_W, 3: width of the note code output.
- BASE_KEY, 97: key code of note 1; key BASE_KEY+i maps to note i+1.
- IDLE_NOTE, 7: note code driven when no note plays; must lie outside 1..NUM_NOTES.
- FILTER_CYCLES, 2: consecutive samples of one key required before the note starts; must be >=1.
- MIN_HOLD, 4: minimum cycles a started note stays on; must be >=1.
- IDLE_TIMEOUT, 1000: cycles in LISTEN with no valid key before returning to IDLE; 0 disables the timeout.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- inicio, input, 1: level; starts free-play mode from IDLE.
- fin, input, 1: level; forces IDLE from any state, overriding every other transition.
- entrada, input, KEY_W: current key code, sampled every rising edge.
- notaSalida, output, NOTE_W: note code (registered).
- contar, output, 1: high while a note is sounding (PLAY or TAIL).
- note_start, output, 1: one-cycle pulse on entry to PLAY from ARM.
- activo, output, 1: high in every state except IDLE.

Behaviour:
- Key decode is combinational: valid = (entrada >= BASE_KEY) && (entrada < BASE_KEY+NUM_NOTES); idx = entrada-BASE_KEY. Comparisons are done at KEY_W+1 bits so that no wrap-around occurs.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state. There is no extra output latency.
- Reset (async) state: IDLE, notaSalida=IDLE_NOTE, contar=0, note_start=0, activo=0, all counters 0, cand=0.
- State IDLE:
  - inicio=1 -> LISTEN.
  - Otherwise stay.
  - Outputs: IDLE_NOTE, contar=0.
- State LISTEN (outputs: IDLE_NOTE, contar=0, activo=1):
  - valid key: latch cand=idx, filt=1.
    - FILTER_CYCLES==1 -> PLAY.
    - Otherwise -> ARM.
  - No valid key: tmo++. If IDLE_TIMEOUT!=0 and tmo reaches IDLE_TIMEOUT -> IDLE.
  - tmo clears on every entry to LISTEN.
- State ARM (outputs as in LISTEN):
  - entrada==cand key: filt++; when filt reaches FILTER_CYCLES -> PLAY.
  - Different valid key: restart with cand=new idx, filt=1, stay in ARM.
  - Invalid key -> LISTEN.
- State PLAY:
  - Entry from ARM: notaSalida=cand+1, contar=1, note_start=1 for one cycle, len=1.
  - len increments each cycle in PLAY and TAIL, saturating at MIN_HOLD.
  - entrada==cand key: stay.
  - Otherwise: len>=MIN_HOLD -> LISTEN; else -> TAIL.
- State TAIL: note is still held, outputs as in PLAY with note_start=0.
  - entrada==cand key -> PLAY (no note_start, len continues).
  - Else, when len>=MIN_HOLD -> LISTEN.
  - Other keys are ignored in TAIL.
- fin=1: next state IDLE from any state, same-cycle priority over inicio and entrada. A note cut by fin ignores MIN_HOLD.
- Simultaneous inicio and fin in IDLE: stay in IDLE.
- Reset asserted mid-note: outputs drop to reset values immediately (async); no note_start on release of reset.
- Unreachable state encodings -> IDLE.
- Latency: with a key stable from sample edge t, notaSalida updates at edge t+FILTER_CYCLES-1 after leaving LISTEN.

Test Plan:
- Defaults; reset, inicio=1 one cycle, entrada=97 held 10 cycles -> LISTEN after 1 edge; notaSalida 7->1 on the 2nd key edge; note_start high exactly 1 cycle; contar=1 until release.
- entrada=98 for 1 cycle then 0 -> ARM then LISTEN; notaSalida stays 7, note_start never pulses.
- entrada=100 for 2 cycles (note 4 starts), then 0 -> TAIL; contar stays 1 until len=4, then notaSalida=7, contar=0. Re-press 100 inside TAIL -> back to PLAY with no new note_start.
- In LISTEN with entrada=101 (out of range) -> no transition. Idle with IDLE_TIMEOUT=8 -> IDLE after 8 cycles, activo=0.
- While note 3 plays, assert fin -> next edge IDLE, notaSalida=7, contar=0. Also assert reset async mid-cycle -> outputs clear before the next edge.
- Parameter sweep NUM_NOTES=6, BASE_KEY=49, NOTE_W=3, FILTER_CYCLES=1 -> key 54 gives note 6 one edge after first sample; key 55 is rejected.
